// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV64-subset multi-cycle controller and its ALU.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_BUS     = 2'd2
    } cause_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    function automatic logic is_known_op(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LD, OP_ST, OP_BR};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the controller and the memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/alu_decode.sv
// Combinational ALU-op decode from opcode/funct3/funct7[5]; flags unsupported encodings.
module alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_e    alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                legal = 1'b1;
                case ({funct7b5, funct3})
                    4'b0000: alu_ctrl = ALU_ADD;
                    4'b1000: alu_ctrl = ALU_SUB;
                    4'b0111: alu_ctrl = ALU_AND;
                    4'b0110: alu_ctrl = ALU_OR;
                    4'b0100: alu_ctrl = ALU_XOR;
                    4'b0001: alu_ctrl = ALU_SLL;
                    4'b0101: alu_ctrl = ALU_SRL;
                    4'b1101: alu_ctrl = ALU_SRA;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_ctrl = ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    default: legal = 1'b0;
                endcase
            end
            OP_LD, OP_ST: legal = 1'b1;
            OP_BR: begin
                alu_ctrl = ALU_SUB;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: fetch/decode/execute/memory/writeback over one memory port,
// with a bus-timeout watchdog and a sticky trap.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus,
    input  logic [31:0]         instr,
    input  logic                alu_zero,
    output logic                ir_we,
    output logic                pc_we,
    output logic                pc_src,
    output logic                alu_src_b,
    output logic [3:0]          alu_ctrl,
    output logic                reg_we,
    output logic                wb_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state_o
);

    state_e            state, state_nx;
    cause_e            cause_q, cause_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        opcode;
    alu_op_e           dec_op;
    logic              dec_legal;
    logic              r_funct7_bad;
    logic              timeout;
    logic              req, we, addr_sel, irwe, pcwe, pcsrc, srcb, regwe, wbsel;
    alu_op_e           alu;
    logic              unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^{instr[24:15], instr[11:7]};
    // The ALU decode only sees funct7[5]; every other funct7 bit must be zero for R-type.
    assign r_funct7_bad = (opcode == OP_R) && ((instr[31:25] & 7'b1011111) != '0);
    assign timeout      = !bus.mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    alu_decode u_alu_decode (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7b5 (instr[30]),
        .alu_ctrl (dec_op),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            if (state_nx != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cause_nx = cause_q;
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        irwe     = 1'b0;
        pcwe     = 1'b0;
        pcsrc    = 1'b0;
        srcb     = 1'b0;
        alu      = ALU_ADD;
        regwe    = 1'b0;
        wbsel    = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (bus.mem_ready) begin
                    irwe     = 1'b1;
                    pcwe     = 1'b1;
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                if (is_known_op(opcode)) begin
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                alu  = dec_op;
                srcb = opcode inside {OP_IMM, OP_LD, OP_ST};
                if (!dec_legal || r_funct7_bad) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else begin
                    case (opcode)
                        OP_LD, OP_ST: state_nx = S_MEM;
                        OP_BR: begin
                            pcwe     = alu_zero;
                            pcsrc    = 1'b1;
                            state_nx = S_FETCH;
                        end
                        default: state_nx = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = (opcode == OP_ST);
                if (bus.mem_ready) begin
                    state_nx = (opcode == OP_ST) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_BUS;
                end
            end
            S_WB: begin
                regwe    = 1'b1;
                wbsel    = (opcode == OP_LD);
                state_nx = S_FETCH;
            end
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase
    end

    // Every output is held low while reset is asserted, regardless of the registered state.
    assign bus.mem_req = req & ~rst;
    assign bus.mem_we  = we & ~rst;
    assign bus.iord    = addr_sel & ~rst;
    assign ir_we       = irwe & ~rst;
    assign pc_we       = pcwe & ~rst;
    assign pc_src      = pcsrc & ~rst;
    assign alu_src_b   = srcb & ~rst;
    assign alu_ctrl    = rst ? '0 : alu;
    assign reg_we      = regwe & ~rst;
    assign wb_sel      = wbsel & ~rst;
    assign trap        = (state == S_TRAP) & ~rst;
    assign trap_cause  = rst ? '0 : cause_q;
    assign state_o     = rst ? '0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs queued then checked.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iord, irwe, pcwe, pcsrc, srcb;
        logic [3:0] alu;
        logic       regwe, wbsel, trp;
        logic [1:0] cause;
    } exp_t;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h40208133;
    localparam logic [31:0] I_SRAI = 32'h4010D093;
    localparam logic [31:0] I_LD   = 32'h0000B183;
    localparam logic [31:0] I_SD   = 32'h0030B023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        alu_zero = 1'b0;
    logic        ir_we, pc_we, pc_src, alu_src_b, reg_we, wb_sel, trap;
    logic [3:0]  alu_ctrl;
    logic [1:0]  trap_cause;
    logic [2:0]  state_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t        sb[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MAX_WAIT(255), .WAIT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [2:0] st, logic req, logic we, logic iord, logic irwe,
                                logic pcwe, logic pcsrc, logic srcb, logic [3:0] alu,
                                logic regwe, logic wbsel, logic trp, logic [1:0] cause);
        return '{st, req, we, iord, irwe, pcwe, pcsrc, srcb, alu, regwe, wbsel, trp, cause};
    endfunction

    function automatic exp_t e_rst();
        return mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 2'd0);
    endfunction
    function automatic exp_t e_fetch(logic rdy);
        return mk(3'd0, 1, 0, 0, rdy, rdy, 0, 0, 4'd0, 0, 0, 0, 2'd0);
    endfunction
    function automatic exp_t e_dec();
        return mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 2'd0);
    endfunction
    function automatic exp_t e_exec(logic srcb, logic [3:0] alu, logic pcwe, logic pcsrc);
        return mk(3'd2, 0, 0, 0, 0, pcwe, pcsrc, srcb, alu, 0, 0, 0, 2'd0);
    endfunction
    function automatic exp_t e_mem(logic we);
        return mk(3'd3, 1, we, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0, 2'd0);
    endfunction
    function automatic exp_t e_wb(logic sel);
        return mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1, sel, 0, 2'd0);
    endfunction
    function automatic exp_t e_trap(logic [1:0] cause);
        return mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, cause);
    endfunction

    task automatic cyc(input logic r, input logic rdy, input logic [31:0] ins, input logic z,
                       input exp_t e, input string tag);
        exp_t want, got;
        @(negedge clk);
        rst           = r;
        bus.mem_ready = rdy;
        instr         = ins;
        alu_zero      = z;
        sb.push_back(e);
        #1;
        want = sb.pop_front();
        got  = exp_t'({state_o, bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src,
                       alu_src_b, alu_ctrl, reg_we, wb_sel, trap, trap_cause});
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;

        cyc(1, 0, I_ADD, 0, e_rst(), "rst0");
        cyc(1, 0, I_ADD, 0, e_rst(), "rst1");

        cyc(0, 1, I_ADD, 0, e_fetch(1), "add_fetch");
        cyc(0, 0, I_ADD, 0, e_dec(), "add_dec");
        cyc(0, 0, I_ADD, 0, e_exec(0, 4'd0, 0, 0), "add_exec");
        cyc(0, 0, I_ADD, 0, e_wb(0), "add_wb");

        cyc(0, 1, I_SUB, 0, e_fetch(1), "sub_fetch");
        cyc(0, 0, I_SUB, 0, e_dec(), "sub_dec");
        cyc(0, 0, I_SUB, 0, e_exec(0, 4'd1, 0, 0), "sub_exec");
        cyc(0, 0, I_SUB, 0, e_wb(0), "sub_wb");

        cyc(0, 1, I_SRAI, 0, e_fetch(1), "srai_fetch");
        cyc(0, 0, I_SRAI, 0, e_dec(), "srai_dec");
        cyc(0, 0, I_SRAI, 0, e_exec(1, 4'd7, 0, 0), "srai_exec");
        cyc(0, 0, I_SRAI, 0, e_wb(0), "srai_wb");

        cyc(0, 1, I_LD, 0, e_fetch(1), "ld_fetch");
        cyc(0, 0, I_LD, 0, e_dec(), "ld_dec");
        cyc(0, 0, I_LD, 0, e_exec(1, 4'd0, 0, 0), "ld_exec");
        for (int i = 0; i < 3; i++) cyc(0, 0, I_LD, 0, e_mem(0), "ld_mem_wait");
        cyc(0, 1, I_LD, 0, e_mem(0), "ld_mem_ready");
        cyc(0, 0, I_LD, 0, e_wb(1), "ld_wb");

        cyc(0, 1, I_SD, 0, e_fetch(1), "sd_fetch");
        cyc(0, 0, I_SD, 0, e_dec(), "sd_dec");
        cyc(0, 0, I_SD, 0, e_exec(1, 4'd0, 0, 0), "sd_exec");
        cyc(0, 1, I_SD, 0, e_mem(1), "sd_mem");

        cyc(0, 1, I_BEQ, 1, e_fetch(1), "beq_t_fetch");
        cyc(0, 0, I_BEQ, 1, e_dec(), "beq_t_dec");
        cyc(0, 0, I_BEQ, 1, e_exec(0, 4'd1, 1, 1), "beq_t_exec");
        cyc(0, 1, I_BEQ, 0, e_fetch(1), "beq_n_fetch");
        cyc(0, 0, I_BEQ, 0, e_dec(), "beq_n_dec");
        cyc(0, 0, I_BEQ, 0, e_exec(0, 4'd1, 0, 1), "beq_n_exec");

        cyc(0, 1, I_SD, 0, e_fetch(1), "sdr_fetch");
        cyc(0, 0, I_SD, 0, e_dec(), "sdr_dec");
        cyc(0, 0, I_SD, 0, e_exec(1, 4'd0, 0, 0), "sdr_exec");
        cyc(0, 0, I_SD, 0, e_mem(1), "sdr_mem");
        cyc(1, 0, I_SD, 0, e_rst(), "sdr_rst");
        cyc(0, 0, I_SD, 0, e_fetch(0), "sdr_after_rst");

        cyc(0, 1, I_BAD, 0, e_fetch(1), "bad_fetch");
        cyc(0, 0, I_BAD, 0, e_dec(), "bad_dec");
        for (int i = 0; i < 10; i++) cyc(0, 1, I_BAD, 0, e_trap(2'd1), "bad_trap_sticky");
        cyc(1, 0, I_BAD, 0, e_rst(), "bad_rst");

        cyc(0, 1, I_MUL, 0, e_fetch(1), "mul_fetch");
        cyc(0, 0, I_MUL, 0, e_dec(), "mul_dec");
        cyc(0, 0, I_MUL, 0, e_exec(0, 4'd0, 0, 0), "mul_exec");
        for (int i = 0; i < 3; i++) cyc(0, 0, I_MUL, 0, e_trap(2'd1), "mul_trap");
        cyc(1, 0, I_MUL, 0, e_rst(), "mul_rst");

        for (int i = 0; i < 255; i++) cyc(0, 0, I_ADD, 0, e_fetch(0), "to_wait");
        cyc(0, 1, I_ADD, 0, e_trap(2'd2), "to_trap");
        cyc(0, 0, I_ADD, 0, e_trap(2'd2), "to_trap_held");
        cyc(1, 0, I_ADD, 0, e_rst(), "to_rst");

        for (int i = 0; i < 254; i++) cyc(0, 0, I_ADD, 0, e_fetch(0), "lim_wait");
        cyc(0, 1, I_ADD, 0, e_fetch(1), "lim_ready");
        cyc(0, 0, I_ADD, 0, e_dec(), "lim_dec");
        cyc(0, 0, I_ADD, 0, e_exec(0, 4'd0, 0, 0), "lim_exec");
        cyc(0, 0, I_ADD, 0, e_wb(0), "lim_wb");
        cyc(0, 0, I_ADD, 0, e_fetch(0), "lim_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
